// File: rtl/cordic_fixedpoint_asel_pkg.sv
// ----------------------------------------------------------------------------
// cordic_fixedpoint_asel_pkg
// Shared definitions for the ASEL phase-address path.
//   - ASEL_ADDR_W   : default theta address width
//   - asel_state_t  : frame FSM states (IDLE, ACCUM, DONE)
//   - atan_const()  : round(atan(2^-addr) * 2^(data_w-3)) for data_w <= 32
// ----------------------------------------------------------------------------
package cordic_fixedpoint_asel_pkg;

   localparam int ASEL_ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } asel_state_t;

   // The base table holds floor(atan(2^-k) * 2^24). Storing the floor rather
   // than the rounded value keeps the final rounding to 2^(data_w-3) correct
   // for entries that sit just below a half LSB (e.g. k=14 at data_w=16).
   // For k >= 8 the cubic term of atan is below one LSB at 2^24, so the floor
   // is simply 2^(24-k) - 1.
   function automatic logic [31:0] atan_const(input logic [31:0] addr,
                                              input int          data_w);
      logic [31:0] base;
      logic [31:0] res;
      case (addr)
         32'd0:   base = 32'd13176794;
         32'd1:   base = 32'd7778716;
         32'd2:   base = 32'd4110059;
         32'd3:   base = 32'd2086330;
         32'd4:   base = 32'd1047213;
         32'd5:   base = 32'd524117;
         32'd6:   base = 32'd262122;
         32'd7:   base = 32'd131069;
         default: begin
            if (addr <= 32'd24) begin
               base = (32'd1 << (32'd24 - addr)) - 32'd1;
            end else begin
               base = 32'd0;
            end
         end
      endcase
      if (data_w < 27) begin
         // round half up while rescaling from 2^24 down to 2^(data_w-3)
         res = (base + (32'd1 << (26 - data_w))) >> (27 - data_w);
      end else if (data_w == 27) begin
         res = base;
      end else begin
         res = base << (data_w - 27);
      end
      return res;
   endfunction

endpackage

// File: rtl/cordic_fixedpoint_phase_addr_decode_4to16.sv
// ----------------------------------------------------------------------------
// cordic_fixedpoint_phase_addr_decode_4to16
// Combinational theta-address to one-hot decoder; exact inverse of the
// priority encoder on the address-selection side.
//   addr   in  ADDR_W        theta address
//   onehot out 2^ADDR_W      one-hot compare vector (bit addr set)
// ----------------------------------------------------------------------------
module cordic_fixedpoint_phase_addr_decode_4to16
   import cordic_fixedpoint_asel_pkg::*;
#(
   parameter int ADDR_W = ASEL_ADDR_W
) (
   input  logic [ADDR_W-1:0]      addr,
   output logic [(2**ADDR_W)-1:0] onehot
);

   // set exactly the bit selected by the address
   always_comb begin
      onehot       = {(2**ADDR_W){1'b0}};
      onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/cordic_fixedpoint_phase_addr_decode_accum.sv
// ----------------------------------------------------------------------------
// cordic_fixedpoint_phase_addr_decode_accum
// Consumes per-micro-rotation theta addresses plus rotation signs, regenerates
// the one-hot compare vector and accumulates signed atan(2^-addr) constants
// into the reconstructed phase of each frame.
//   iClk, iRst          clock, synchronous active-high reset
//   iStart              start (or restart) a frame
//   iAddr_valid/oAddr_ready, iTheta_addr, iSign, iLast : address beat stream
//   oOnehot             one-hot vector of the last accepted beat
//   oPhase/oPhase_valid/iPhase_ready : frame result handshake
//   oBusy               frame in progress
// ----------------------------------------------------------------------------
module cordic_fixedpoint_phase_addr_decode_accum
   import cordic_fixedpoint_asel_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = ASEL_ADDR_W,
   parameter int MAX_ITER = 4
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iStart,
   input  logic                     iAddr_valid,
   output logic                     oAddr_ready,
   input  logic [ADDR_W-1:0]        iTheta_addr,
   input  logic                     iSign,
   input  logic                     iLast,
   output logic [(2**ADDR_W)-1:0]   oOnehot,
   output logic [DATA_W-1:0]        oPhase,
   output logic                     oPhase_valid,
   input  logic                     iPhase_ready,
   output logic                     oBusy
);

   localparam int CNT_W = $clog2(MAX_ITER + 1);
   localparam int OH_W  = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

   asel_state_t          state_r,  state_nxt_s;
   logic [DATA_W-1:0]    acc_r,    acc_nxt_s,    acc_base_s;
   logic [CNT_W-1:0]     cnt_r,    cnt_nxt_s,    cnt_base_s;
   logic [OH_W-1:0]      onehot_r, onehot_nxt_s, onehot_dec_s;
   logic [DATA_W-1:0]    phase_r,  phase_nxt_s;
   logic                 valid_r,  valid_nxt_s;
   logic                 beat_s;
   logic [31:0]          tab_full_s;
   logic [DATA_W-1:0]    tab_s;

   cordic_fixedpoint_phase_addr_decode_4to16 #(
      .ADDR_W (ADDR_W)
   ) u_decode (
      .addr   (iTheta_addr),
      .onehot (onehot_dec_s)
   );

   assign tab_full_s   = atan_const(32'(iTheta_addr), DATA_W);
   assign tab_s        = tab_full_s[DATA_W-1:0];
   assign beat_s       = iAddr_valid & oAddr_ready;

   assign oAddr_ready  = (state_r == ST_ACCUM);
   assign oBusy        = (state_r != ST_IDLE);
   assign oOnehot      = onehot_r;
   assign oPhase       = phase_r;
   assign oPhase_valid = valid_r;

   // frame FSM, accumulator, counter and result next-state logic
   always_comb begin
      state_nxt_s  = state_r;
      acc_nxt_s    = acc_r;
      cnt_nxt_s    = cnt_r;
      onehot_nxt_s = onehot_r;
      phase_nxt_s  = phase_r;
      valid_nxt_s  = valid_r;
      acc_base_s   = acc_r;
      cnt_base_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (iStart) begin
               state_nxt_s  = ST_ACCUM;
               acc_nxt_s    = {DATA_W{1'b0}};
               cnt_nxt_s    = {CNT_W{1'b0}};
               onehot_nxt_s = {OH_W{1'b0}};
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            // a restart clears the frame; a same-cycle beat becomes beat 0
            if (iStart) begin
               acc_base_s   = {DATA_W{1'b0}};
               cnt_base_s   = {CNT_W{1'b0}};
               onehot_nxt_s = {OH_W{1'b0}};
            end else begin
               acc_base_s   = acc_r;
               cnt_base_s   = cnt_r;
            end
            if (beat_s) begin
               if (iSign) begin
                  acc_nxt_s = acc_base_s - tab_s;
               end else begin
                  acc_nxt_s = acc_base_s + tab_s;
               end
               cnt_nxt_s    = cnt_base_s + CNT_W'(1);
               onehot_nxt_s = onehot_dec_s;
               if (iLast || (cnt_base_s == CNT_LAST)) begin
                  state_nxt_s = ST_DONE;
                  phase_nxt_s = acc_nxt_s;
                  valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_ACCUM;
               end
            end else begin
               acc_nxt_s = acc_base_s;
               cnt_nxt_s = cnt_base_s;
            end
         end
         ST_DONE: begin
            if (iPhase_ready) begin
               state_nxt_s = ST_IDLE;
               valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_r  <= ST_IDLE;
         acc_r    <= {DATA_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         onehot_r <= {OH_W{1'b0}};
         phase_r  <= {DATA_W{1'b0}};
         valid_r  <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         acc_r    <= acc_nxt_s;
         cnt_r    <= cnt_nxt_s;
         onehot_r <= onehot_nxt_s;
         phase_r  <= phase_nxt_s;
         valid_r  <= valid_nxt_s;
      end
   end

endmodule
